// File: rtl/sd_pkg.sv
// Shared constants for the SPI-mode SD card responder: command indices, R1 bit layout,
// frame/response widths and the FSM state type.
package sd_pkg;

  typedef enum logic [2:0] {HUNT, RECV, DECODE, NCR, RESP} sdState_t;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;

  localparam logic [5:0] FRAME_LAST = 6'd47;
  localparam logic [5:0] CRC_SPAN   = 6'd40;
  localparam logic [5:0] R1_BITS    = 6'd8;
  localparam logic [5:0] R3_BITS    = 6'd40;

  function automatic logic [7:0] r1Word(input logic illegal, input logic crcErr, input logic idle);
    logic [7:0] r;
    r             = 8'h00;
    r[R1_IDLE]    = idle;
    r[R1_ILLEGAL] = illegal;
    r[R1_CRC_ERR] = crcErr;
    return r;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enable, MSB-first command stream.
module sd_crc7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       dataBit,
  output logic [6:0] crc
);

  logic feedback;
  assign feedback = dataBit ^ crc[6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       crc <= '0;
    else if (clear)  crc <= '0;
    else if (enable) crc <= {crc[5:3], crc[2] ^ feedback, crc[1:0], feedback};
  end

endmodule

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model: decodes 48-bit host command frames and answers with R1/R3/R7 on DO.
// Define SD_RESP_CRC_CHECK_EN to verify the frame CRC7 and answer bad frames with a CRC error.
module sd_spi_card_responder
  import sd_pkg::*;
#(
  parameter int          NCR_BYTES      = 1,
  parameter int          ACMD41_RETRIES = 3,
  parameter logic [31:0] OCR_VALUE      = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        DI,
  output logic        DO,
  output logic        cmdStrobe,
  output logic [5:0]  cmdIndex,
  output logic [31:0] cmdArgument,
  output logic        isIdle,
  output logic        isReady
);

  localparam logic [6:0] NCR_LAST    = 7'(NCR_BYTES * 8 - 1);
  localparam logic [7:0] RETRY_LIMIT = 8'(ACMD41_RETRIES);

  logic [1:0]  sclkSync, csSync, diSync;
  logic        sclkPrev, sclkRise, sclkFall, csHigh, diS;
  sdState_t    state, stateNext;
  logic        startSeen, crcOk, appCmd;
  logic [5:0]  bitCount, respCount, respLen, rspLen;
  logic [6:0]  ncrCount;
  logic [7:0]  acmdCount, acmdNext;
  logic [47:0] frame;
  logic [39:0] respReg, rspWord;
  logic        idleNext, readyNext, appNext;

  assign sclkRise = sclkSync[1] & ~sclkPrev;
  assign sclkFall = ~sclkSync[1] & sclkPrev;
  assign csHigh   = csSync[1];
  assign diS      = diSync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclkSync <= 2'b00;
      csSync   <= 2'b11;
      diSync   <= 2'b11;
      sclkPrev <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[0], SCLK};
      csSync   <= {csSync[0], CS};
      diSync   <= {diSync[0], DI};
      sclkPrev <= sclkSync[1];
    end
  end

`ifdef SD_RESP_CRC_CHECK_EN
  logic [6:0] crcValue;
  logic       crcClear, crcEnable, unusedFrameBits;
  // Start bit contributes nothing from a zeroed register, so accumulation starts at the transmit bit.
  assign crcClear  = !csHigh && sclkRise && state == HUNT && !startSeen;
  assign crcEnable = !csHigh && sclkRise &&
                     ((state == HUNT && startSeen && diS) || (state == RECV && bitCount < CRC_SPAN));
  sd_crc7 crcUnit (
    .clk(clk), .reset(reset), .clear(crcClear), .enable(crcEnable), .dataBit(diS), .crc(crcValue)
  );
  assign crcOk           = (crcValue == frame[7:1]);
  assign unusedFrameBits = ^{frame[47:46], frame[0]};
`else
  logic unusedFrameBits;
  assign crcOk           = 1'b1;
  assign unusedFrameBits = ^{frame[47:46], frame[7:0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (csHigh) stateNext = HUNT;
    else begin
      case (state)
        HUNT:    if (sclkRise && startSeen && diS) stateNext = RECV;
        RECV:    if (sclkRise && bitCount == FRAME_LAST) stateNext = diS ? DECODE : HUNT;
        DECODE:  stateNext = NCR;
        NCR:     if (sclkFall && ncrCount == NCR_LAST) stateNext = RESP;
        RESP:    if (sclkFall && respCount == respLen) stateNext = HUNT;
        default: stateNext = HUNT;
      endcase
    end
  end

  // Response selection and card-state update for the frame held in 'frame'.
  always_comb begin
    rspWord   = {r1Word(1'b1, 1'b0, isIdle), 32'hFFFF_FFFF};
    rspLen    = R1_BITS;
    idleNext  = isIdle;
    readyNext = isReady;
    appNext   = 1'b0;
    acmdNext  = acmdCount;
    if (!crcOk) begin
      rspWord = {r1Word(1'b0, 1'b1, isIdle), 32'hFFFF_FFFF};
      appNext = appCmd;
    end else begin
      case (frame[45:40])
        CMD0: begin
          rspWord[39:32] = 8'h01;
          idleNext       = 1'b1;
          readyNext      = 1'b0;
          acmdNext       = 8'd0;
        end
        CMD8: begin
          rspWord = {isIdle ? 8'h01 : 8'h05, 20'h0, frame[19:8]};
          rspLen  = R3_BITS;
        end
        CMD55: begin
          rspWord[39:32] = r1Word(1'b0, 1'b0, isIdle);
          appNext        = 1'b1;
        end
        CMD41: begin
          if (appCmd) begin
            if (acmdCount < RETRY_LIMIT) begin
              rspWord[39:32] = 8'h01;
              acmdNext       = acmdCount + 8'd1;
            end else begin
              rspWord[39:32] = 8'h00;
              idleNext       = 1'b0;
              readyNext      = 1'b1;
            end
          end
        end
        CMD58: begin
          rspWord = {r1Word(1'b0, 1'b0, isIdle), OCR_VALUE};
          rspLen  = R3_BITS;
        end
        CMD16:   rspWord[39:32] = isReady ? 8'h00 : r1Word(1'b0, 1'b0, isIdle);
        default: ;
      endcase
    end
  end

  // Frame shifting, response serialisation and card state; CS high aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DO          <= 1'b1;
      cmdStrobe   <= 1'b0;
      cmdIndex    <= '0;
      cmdArgument <= '0;
      isIdle      <= 1'b1;
      isReady     <= 1'b0;
      appCmd      <= 1'b0;
      acmdCount   <= '0;
      startSeen   <= 1'b0;
      bitCount    <= '0;
      frame       <= '0;
      ncrCount    <= '0;
      respCount   <= '0;
      respLen     <= R1_BITS;
      respReg     <= '1;
    end else begin
      cmdStrobe <= 1'b0;
      if (csHigh) begin
        DO        <= 1'b1;
        startSeen <= 1'b0;
        bitCount  <= '0;
        ncrCount  <= '0;
        respCount <= '0;
      end else begin
        case (state)
          HUNT: begin
            if (sclkRise) begin
              if (!startSeen) startSeen <= ~diS;
              else begin
                startSeen <= 1'b0;
                if (diS) begin
                  frame    <= {46'b0, 2'b01};
                  bitCount <= 6'd2;
                end
              end
            end
          end
          RECV: begin
            if (sclkRise) begin
              frame    <= {frame[46:0], diS};
              bitCount <= bitCount + 6'd1;
            end
          end
          DECODE: begin
            cmdIndex    <= frame[45:40];
            cmdArgument <= frame[39:8];
            cmdStrobe   <= 1'b1;
            respReg     <= rspWord;
            respLen     <= rspLen;
            isIdle      <= idleNext;
            isReady     <= readyNext;
            appCmd      <= appNext;
            acmdCount   <= acmdNext;
            ncrCount    <= '0;
            respCount   <= '0;
          end
          NCR: begin
            if (sclkFall) begin
              DO       <= 1'b1;
              ncrCount <= ncrCount + 7'd1;
            end
          end
          RESP: begin
            if (sclkFall) begin
              if (respCount == respLen) DO <= 1'b1;
              else begin
                DO        <= respReg[39];
                respReg   <= {respReg[38:0], 1'b1};
                respCount <= respCount + 6'd1;
              end
            end
          end
          default: DO <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder: plays a host SPI master through the SD init sequence.
// Expected responses are hand-computed; the SD_RESP_CRC_CHECK_EN block exercises the CRC error path.
module tb_sd_spi_card_responder;
  import sd_pkg::*;

  logic        clk = 1'b0;
  logic        reset, SCLK, CS, DI;
  logic        DO, cmdStrobe, isIdle, isReady;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArgument;

  int checks = 0, errors = 0, strobeCount = 0, expStrobes = 0;
  logic [7:0]  filler;
  logic [39:0] resp;
  logic        bitR;

  sd_spi_card_responder dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .DI(DI), .DO(DO),
    .cmdStrobe(cmdStrobe), .cmdIndex(cmdIndex), .cmdArgument(cmdArgument),
    .isIdle(isIdle), .isReady(isReady)
  );

  always #5 clk = ~clk;

  // Count decoded-frame pulses on the inactive edge.
  always @(negedge clk) if (!reset && cmdStrobe) strobeCount++;

  task automatic checkOutput(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic xferBit(input logic b, output logic r);
    DI = b;
    #80;
    r    = DO;
    SCLK = 1'b1;
    #80;
    SCLK = 1'b0;
  endtask

  task automatic xferByte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xferBit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic sendFrame(input logic [5:0] idx, input logic [31:0] arg, input logic badCrc);
    logic [39:0] head;
    logic [47:0] f;
    logic [7:0]  junk;
    head = {2'b01, idx, arg};
    f    = {head, badCrc ? 8'h01 : {crc7(head), 1'b1}};
    for (int k = 0; k < 6; k++) xferByte(f[47 - 8*k -: 8], junk);
  endtask

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic badCrc,
                               input int nResp, output logic [7:0] fill, output logic [39:0] rsp);
    logic [7:0] b;
    CS = 1'b0;
    #80;
    sendFrame(idx, arg, badCrc);
    xferByte(8'hFF, fill);
    rsp = '0;
    for (int k = 0; k < nResp; k++) begin
      xferByte(8'hFF, b);
      rsp = {rsp[31:0], b};
    end
    CS = 1'b1;
    DI = 1'b1;
    #160;
  endtask

  initial begin
    SCLK  = 1'b0;
    CS    = 1'b1;
    DI    = 1'b1;
    reset = 1'b1;
    #13;
    checkOutput("rstDO", 40'(DO), 40'h1);
    checkOutput("rstStrobe", 40'(cmdStrobe), 40'h0);
    checkOutput("rstIndex", 40'(cmdIndex), 40'h0);
    checkOutput("rstArg", 40'(cmdArgument), 40'h0);
    checkOutput("rstIdle", 40'(isIdle), 40'h1);
    checkOutput("rstReady", 40'(isReady), 40'h0);
    #10 reset = 1'b0;
    #80;

    applyStimulus(CMD0, 32'h0, 1'b0, 1, filler, resp);
    expStrobes++;
    checkOutput("cmd0Ncr", 40'(filler), 40'hFF);
    checkOutput("cmd0R1", resp, 40'h01);
    checkOutput("cmd0Strobe", 40'(strobeCount), 40'(expStrobes));
    checkOutput("cmd0Index", 40'(cmdIndex), 40'h0);
    checkOutput("cmd0Idle", 40'(isIdle), 40'h1);

    applyStimulus(CMD8, 32'h000001AA, 1'b0, 5, filler, resp);
    expStrobes++;
    checkOutput("cmd8R7", resp, 40'h01_000001AA);
    checkOutput("cmd8Arg", 40'(cmdArgument), 40'h1AA);
    checkOutput("cmd8Index", 40'(cmdIndex), 40'd8);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(CMD55, 32'h0, 1'b0, 1, filler, resp);
      checkOutput("cmd55R1", resp, 40'h01);
      applyStimulus(CMD41, 32'h40000000, 1'b0, 1, filler, resp);
      checkOutput("acmd41R1", resp, (i < 3) ? 40'h01 : 40'h00);
      expStrobes += 2;
    end
    checkOutput("initReady", 40'(isReady), 40'h1);
    checkOutput("initIdle", 40'(isIdle), 40'h0);
    checkOutput("initStrobes", 40'(strobeCount), 40'(expStrobes));

    applyStimulus(CMD58, 32'h0, 1'b0, 5, filler, resp);
    checkOutput("cmd58R3", resp, 40'h00_C0FF8000);
    applyStimulus(CMD16, 32'h1, 1'b0, 1, filler, resp);
    checkOutput("cmd16R1", resp, 40'h00);
    applyStimulus(CMD41, 32'h40000000, 1'b0, 1, filler, resp);
    checkOutput("cmd41NoApp", resp, 40'h04);
    applyStimulus(CMD8, 32'h000001AA, 1'b0, 5, filler, resp);
    checkOutput("cmd8NotIdle", resp, 40'h05_000001AA);
    expStrobes += 4;

    // Reset asserted while the CMD58 R1 (0x00) is being shifted out.
    CS = 1'b0;
    #80;
    sendFrame(CMD58, 32'h0, 1'b0);
    xferByte(8'hFF, filler);
    xferBit(1'b1, bitR);
    checkOutput("cmd58FirstBit", 40'(bitR), 40'h0);
    #40;
    checkOutput("midRespDO", 40'(DO), 40'h0);
    reset = 1'b1;
    #1;
    checkOutput("asyncRstDO", 40'(DO), 40'h1);
    checkOutput("asyncRstReady", 40'(isReady), 40'h0);
    checkOutput("asyncRstIdle", 40'(isIdle), 40'h1);
    checkOutput("asyncRstIndex", 40'(cmdIndex), 40'h0);
    #19 reset = 1'b0;
    CS = 1'b1;
    DI = 1'b1;
    #160;
    expStrobes++;

    // Partial frame aborted by CS, then a full CMD0.
    CS = 1'b0;
    #80;
    begin
      logic [47:0] f;
      f = 48'h40_0000_0000_95;
      for (int i = 0; i < 20; i++) xferBit(f[47 - i], bitR);
    end
    CS = 1'b1;
    DI = 1'b1;
    #400;
    checkOutput("partialNoStrobe", 40'(strobeCount), 40'(expStrobes));
    applyStimulus(CMD0, 32'h0, 1'b0, 1, filler, resp);
    expStrobes++;
    checkOutput("cmd0AfterAbort", resp, 40'h01);
    checkOutput("cmd0AfterStrobe", 40'(strobeCount), 40'(expStrobes));

`ifdef SD_RESP_CRC_CHECK_EN
    applyStimulus(CMD0, 32'h0, 1'b1, 1, filler, resp);
    expStrobes++;
    checkOutput("badCrcR1", resp, 40'h09);
    checkOutput("badCrcStrobe", 40'(strobeCount), 40'(expStrobes));
    checkOutput("badCrcIdle", 40'(isIdle), 40'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
